// File: rtl/morse_tx_ctrl.sv
// Plays one Morse letter (MSB-first code/length pair) on a single LED with
// programmable unit timing, start/busy/done handshake and synchronous abort.
module morse_tx_ctrl #(
  parameter int UNIT_CYCLES = 25_000_000,
  parameter int CODE_W      = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [CODE_W-1:0] code_i,
  input  logic [2:0]        len_i,
  input  logic              abort_i,
  output logic              led_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [2:0]        sym_idx_o,
  output logic [1:0]        state_o
);

  localparam int TW = $clog2(3 * UNIT_CYCLES + 1);
  localparam logic [TW-1:0] DOT_T  = TW'(UNIT_CYCLES);
  localparam logic [TW-1:0] DASH_T = TW'(3 * UNIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  // Handshake: start_i is a single-cycle request honoured only in IDLE
  // (including the cycle done_o is high); busy_o covers the whole letter and
  // done_o pulses for one cycle on normal completion only.
  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [CODE_W-1:0] shift_q, shift_d;
  logic [2:0]        len_q, len_d;
  logic [2:0]        idx_q, idx_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [2:0]        len_eff;
  logic [2:0]        shamt;
  logic [CODE_W-1:0] aligned;

  // Left-align the used bits so the current symbol is always the shifter MSB.
  always_comb begin
    len_eff = (len_i > 3'(CODE_W)) ? 3'(CODE_W) : len_i;
    shamt   = 3'(CODE_W) - len_eff;
    aligned = code_i << shamt;
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    shift_d = shift_q;
    len_d   = len_q;
    idx_d   = idx_q;
    led_d   = led_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          idx_d = 3'd0;
          if (len_eff != 3'd0) begin
            shift_d = aligned;
            len_d   = len_eff;
            timer_d = aligned[CODE_W-1] ? DASH_T : DOT_T;
            led_d   = 1'b1;
            busy_d  = 1'b1;
            state_d = MARK;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      MARK: begin
        if (abort_i) begin
          state_d = IDLE;
          timer_d = '0;
          led_d   = 1'b0;
          busy_d  = 1'b0;
        end else if (timer_q == TW'(1)) begin
          idx_d = idx_q + 3'd1;
          led_d = 1'b0;
          if (idx_q + 3'd1 == len_q) begin
            state_d = IDLE;
            timer_d = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = SPACE;
            timer_d = DOT_T;
            shift_d = shift_q << 1;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      SPACE: begin
        if (abort_i) begin
          state_d = IDLE;
          timer_d = '0;
          led_d   = 1'b0;
          busy_d  = 1'b0;
        end else if (timer_q == TW'(1)) begin
          state_d = MARK;
          timer_d = shift_q[CODE_W-1] ? DASH_T : DOT_T;
          led_d   = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
        led_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      timer_q <= '0;
      shift_q <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      shift_q <= shift_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign led_o     = led_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign sym_idx_o = idx_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_morse_tx_ctrl.sv
// Directed bench for morse_tx_ctrl with UNIT_CYCLES=4: dot=4, dash=12, gap=4.
module tb_morse_tx_ctrl;

  localparam int U = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MARK = 2'd1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] code = 4'd0;
  logic [2:0] len = 3'd0;
  logic       abort = 1'b0;
  logic       led, busy, done;
  logic [2:0] sym_idx;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  morse_tx_ctrl #(.UNIT_CYCLES(U), .CODE_W(4)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .code_i    (code),
    .len_i     (len),
    .abort_i   (abort),
    .led_o     (led),
    .busy_o    (busy),
    .done_o    (done),
    .sym_idx_o (sym_idx),
    .state_o   (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_led(input string tag, input logic val, input int n);
    for (int i = 0; i < n; i++) begin
      check(tag, 32'(led), 32'(val));
      check({tag, "_nodone"}, 32'(done), 0);
      tick();
    end
  endtask

  task automatic send(input logic [3:0] c, input logic [2:0] l);
    code  = c;
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int cnt;
    #12;
    rst_n = 1'b1;
    tick();
    check("rst_led", 32'(led), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_idx", 32'(sym_idx), 0);
    check("rst_state", 32'(state), 32'(ST_IDLE));

    // "A": dot, dash
    send(4'b0001, 3'd2);
    check("a_busy", 32'(busy), 1);
    check("a_state", 32'(state), 32'(ST_MARK));
    expect_led("a_dot", 1'b1, U);
    expect_led("a_gap", 1'b0, U);
    expect_led("a_dash", 1'b1, 3 * U);
    check("a_done", 32'(done), 1);
    check("a_led_end", 32'(led), 0);
    check("a_busy_end", 32'(busy), 0);
    check("a_idx", 32'(sym_idx), 2);
    tick();
    check("a_done_1cyc", 32'(done), 0);

    // zero length: immediate done, no LED
    send(4'b1111, 3'd0);
    check("z_done", 32'(done), 1);
    check("z_led", 32'(led), 0);
    check("z_busy", 32'(busy), 0);
    tick();
    check("z_done_1cyc", 32'(done), 0);
    check("z_busy2", 32'(busy), 0);

    // clamp len 7 -> 4 dashes: 4*12 + 3*4 = 60 busy cycles
    send(4'b1111, 3'd7);
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      tick();
    end
    check("clamp_busy_cycles", cnt, 60);
    check("clamp_done", 32'(done), 1);
    check("clamp_idx", 32'(sym_idx), 4);
    tick();

    // len 3, code 1010: bit 3 ignored -> dot, dash, dot
    send(4'b1010, 3'd3);
    expect_led("r_dot1", 1'b1, U);
    expect_led("r_gap1", 1'b0, U);
    expect_led("r_dash", 1'b1, 3 * U);
    expect_led("r_gap2", 1'b0, U);
    expect_led("r_dot2", 1'b1, U);
    check("r_done", 32'(done), 1);
    check("r_idx", 32'(sym_idx), 3);
    tick();

    // start pulsed mid-dash is ignored; start on done cycle is taken at once
    send(4'b0001, 3'd2);
    expect_led("i_dot", 1'b1, U);
    expect_led("i_gap", 1'b0, U);
    expect_led("i_dash_a", 1'b1, 5);
    code  = 4'b0000;
    len   = 3'd1;
    start = 1'b1;
    expect_led("i_dash_b", 1'b1, 1);
    start = 1'b0;
    expect_led("i_dash_c", 1'b1, 6);
    check("i_done", 32'(done), 1);
    check("i_idx", 32'(sym_idx), 2);
    send(4'b0000, 3'd1);
    check("b2b_busy", 32'(busy), 1);
    check("b2b_idx", 32'(sym_idx), 0);
    expect_led("b2b_dot", 1'b1, U);
    check("b2b_done", 32'(done), 1);
    check("b2b_idx_end", 32'(sym_idx), 1);
    tick();

    // abort in cycle 6 of a dash
    send(4'b0001, 3'd1);
    expect_led("ab_dash", 1'b1, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_led", 32'(led), 0);
    check("ab_busy", 32'(busy), 0);
    check("ab_done", 32'(done), 0);
    check("ab_idx", 32'(sym_idx), 0);
    check("ab_state", 32'(state), 32'(ST_IDLE));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ab_no_done", 32'(done), 0);
    end
    // start and abort together in IDLE: start wins
    abort = 1'b1;
    send(4'b0000, 3'd1);
    abort = 1'b0;
    check("ab_start_busy", 32'(busy), 1);
    expect_led("ab_start_dot", 1'b1, U);
    check("ab_start_done", 32'(done), 1);
    tick();

    // asynchronous reset mid-space
    send(4'b0001, 3'd2);
    expect_led("rs_dot", 1'b1, U);
    expect_led("rs_gap", 1'b0, 2);
    code  = 4'b1111;
    rst_n = 1'b0;
    #2;
    check("rs_busy_async", 32'(busy), 0);
    check("rs_led_async", 32'(led), 0);
    check("rs_state_async", 32'(state), 32'(ST_IDLE));
    rst_n = 1'b1;
    tick();
    check("rs_idle_busy", 32'(busy), 0);
    check("rs_idle_done", 32'(done), 0);
    check("rs_idle_idx", 32'(sym_idx), 0);
    send(4'b0000, 3'd1);
    expect_led("rs_new_dot", 1'b1, U);
    check("rs_new_done", 32'(done), 1);
    check("rs_new_idx", 32'(sym_idx), 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
